// File: rtl/morse_symbol_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : morse_symbol_ctrl
// Brief    : Times Morse key presses and releases, classifies each press as a
//            dot or a dash, drives the symbol shift register, and reports
//            completed letters and word gaps.
// Revision : 1.0 - initial release
// ============================================================================
module morse_symbol_ctrl #(
  parameter int N          = 5,
  parameter int CW         = 8,
  parameter int MIN_PRESS  = 1,
  parameter int DOT_MAX    = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     key,
  output logic                     shift,
  output logic                     SI,
  output logic                     letter_valid,
  output logic [$clog2(N+1)-1:0]   letter_len,
  output logic                     letter_err,
  output logic                     word_gap
);

  localparam int LW = $clog2(N+1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_press = 2'd1;
  localparam logic [1:0] c_st_gap   = 2'd2;

  localparam logic [CW-1:0] c_cnt_max    = {CW{1'b1}};
  localparam logic [CW-1:0] c_min_press  = CW'(MIN_PRESS);
  localparam logic [CW-1:0] c_dot_max    = CW'(DOT_MAX);
  // Gap thresholds are compared against gap_cnt+1, which needs one extra bit
  // so a saturated counter never wraps onto a small threshold.
  localparam logic [CW:0]   c_letter_gap = (CW+1)'(LETTER_GAP);
  localparam logic [CW:0]   c_word_gap   = (CW+1)'(WORD_GAP);
  localparam logic [LW-1:0] c_sym_max    = LW'(N);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] dur_cnt_q, dur_cnt_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic [LW-1:0] sym_cnt_q, sym_cnt_d;
  logic          ovf_q, ovf_d;
  logic          armed_q, armed_d;

  logic          shift_q, shift_d;
  logic          si_q, si_d;
  logic          letter_valid_q, letter_valid_d;
  logic [LW-1:0] letter_len_q, letter_len_d;
  logic          letter_err_q, letter_err_d;
  logic          word_gap_q, word_gap_d;

  logic [CW-1:0] w_dur_inc;
  logic [CW-1:0] w_gap_inc;
  logic [CW:0]   w_gap_plus1;

  assign w_dur_inc   = (dur_cnt_q == c_cnt_max) ? dur_cnt_q : dur_cnt_q + 1'b1;
  assign w_gap_inc   = (gap_cnt_q == c_cnt_max) ? gap_cnt_q : gap_cnt_q + 1'b1;
  assign w_gap_plus1 = {1'b0, gap_cnt_q} + 1'b1;

  // Next-state logic: a key edge always takes priority over a tick in the
  // same cycle, so that tick is dropped rather than counted.
  always_comb begin
    state_d        = state_q;
    dur_cnt_d      = dur_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    sym_cnt_d      = sym_cnt_q;
    ovf_d          = ovf_q;
    armed_d        = armed_q;
    shift_d        = 1'b0;
    si_d           = si_q;
    letter_valid_d = 1'b0;
    letter_len_d   = letter_len_q;
    letter_err_d   = letter_err_q;
    word_gap_d     = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (key) begin
          state_d   = c_st_press;
          dur_cnt_d = '0;
          armed_d   = 1'b0;
        end else if (tick) begin
          // gap_cnt keeps running from the last release of the letter.
          gap_cnt_d = w_gap_inc;
          if (armed_q && (w_gap_plus1 == c_word_gap)) begin
            word_gap_d = 1'b1;
            armed_d    = 1'b0;
          end
        end
      end

      c_st_press: begin
        if (!key) begin
          gap_cnt_d = '0;
          if (dur_cnt_q < c_min_press) begin
            // Glitch: drop it, resume whatever was going on before.
            state_d = (sym_cnt_q != '0) ? c_st_gap : c_st_idle;
          end else begin
            state_d = c_st_gap;
            if (sym_cnt_q < c_sym_max) begin
              shift_d   = 1'b1;
              si_d      = (dur_cnt_q >= c_dot_max);
              sym_cnt_d = sym_cnt_q + 1'b1;
            end else begin
              // Register already full: keep the first N symbols, flag it.
              ovf_d = 1'b1;
            end
          end
        end else if (tick) begin
          dur_cnt_d = w_dur_inc;
        end
      end

      c_st_gap: begin
        if (key) begin
          state_d   = c_st_press;
          dur_cnt_d = '0;
        end else if (tick) begin
          gap_cnt_d = w_gap_inc;
          if (w_gap_plus1 == c_letter_gap) begin
            letter_valid_d = 1'b1;
            letter_len_d   = sym_cnt_q;
            letter_err_d   = ovf_q;
            sym_cnt_d      = '0;
            ovf_d          = 1'b0;
            armed_d        = 1'b1;
            state_d        = c_st_idle;
          end
        end
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // State and output registers; reset aborts any letter in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= c_st_idle;
      dur_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      sym_cnt_q      <= '0;
      ovf_q          <= 1'b0;
      armed_q        <= 1'b0;
      shift_q        <= 1'b0;
      si_q           <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_len_q   <= '0;
      letter_err_q   <= 1'b0;
      word_gap_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dur_cnt_q      <= dur_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      sym_cnt_q      <= sym_cnt_d;
      ovf_q          <= ovf_d;
      armed_q        <= armed_d;
      shift_q        <= shift_d;
      si_q           <= si_d;
      letter_valid_q <= letter_valid_d;
      letter_len_q   <= letter_len_d;
      letter_err_q   <= letter_err_d;
      word_gap_q     <= word_gap_d;
    end
  end

  assign shift        = shift_q;
  assign SI           = si_q;
  assign letter_valid = letter_valid_q;
  assign letter_len   = letter_len_q;
  assign letter_err   = letter_err_q;
  assign word_gap     = word_gap_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_symbol_ctrl
// Brief    : Directed scoreboard bench for morse_symbol_ctrl. Expected
//            shift / letter / word-gap events are queued in order as the
//            stimulus is driven and popped as the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_ctrl;

  localparam int K_SHIFT  = 1;
  localparam int K_LETTER = 2;
  localparam int K_WORD   = 3;

  typedef struct {
    int   kind;
    logic si;
    int   len;
    logic err;
    int   q;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic key = 1'b0;
  logic sel = 1'b0;

  logic       key_a, key_g;
  logic       a_shift, a_si, a_lv, a_err, a_wg;
  logic [2:0] a_len;
  logic       g_shift, g_si, g_lv, g_err, g_wg;
  logic [2:0] g_len;

  logic       m_shift, m_si, m_lv, m_err, m_wg;
  logic [2:0] m_len;
  logic [4:0] q_reg;

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;

  assign key_a = sel ? 1'b0 : key;
  assign key_g = sel ? key : 1'b0;

  morse_symbol_ctrl dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .key(key_a),
    .shift(a_shift), .SI(a_si), .letter_valid(a_lv),
    .letter_len(a_len), .letter_err(a_err), .word_gap(a_wg)
  );

  morse_symbol_ctrl #(.MIN_PRESS(2)) dut_g (
    .clk(clk), .reset_n(reset_n), .tick(tick), .key(key_g),
    .shift(g_shift), .SI(g_si), .letter_valid(g_lv),
    .letter_len(g_len), .letter_err(g_err), .word_gap(g_wg)
  );

  assign m_shift = sel ? g_shift : a_shift;
  assign m_si    = sel ? g_si    : a_si;
  assign m_lv    = sel ? g_lv    : a_lv;
  assign m_len   = sel ? g_len   : a_len;
  assign m_err   = sel ? g_err   : a_err;
  assign m_wg    = sel ? g_wg    : a_wg;

  // Stand-in for the downstream symbol register (shift left, SI into LSB).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_reg <= '0;
    else if (m_shift) q_reg <= {q_reg[3:0], m_si};
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic exp_shift(input logic si);
    sb.push_back('{K_SHIFT, si, 0, 1'b0, 0});
  endtask

  task automatic exp_letter(input int len, input logic err, input int q);
    sb.push_back('{K_LETTER, 1'b0, len, err, q});
  endtask

  task automatic exp_word();
    sb.push_back('{K_WORD, 1'b0, 0, 1'b0, 0});
  endtask

  // One clock with given key/tick levels.
  task automatic cyc(input logic k, input logic t);
    key  = k;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  // n tick periods of key level k; the key change lands on a non-tick cycle.
  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(k, 1'b0);
      cyc(k, 1'b1);
    end
  endtask

  task automatic press(input int n); run(1'b1, n); endtask
  task automatic gap(input int n);   run(1'b0, n); endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_shift"}, int'(a_shift), 0);
    chk({tag, "_si"},    int'(a_si),    0);
    chk({tag, "_lv"},    int'(a_lv),    0);
    chk({tag, "_len"},   int'(a_len),   0);
    chk({tag, "_err"},   int'(a_err),   0);
    chk({tag, "_wg"},    int'(a_wg),    0);
  endtask

  // Scoreboard monitor: every DUT event must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && (m_shift || m_lv || m_wg)) begin
      int  kind_obs;
      int  mask;
      ev_t e;
      kind_obs = m_shift ? K_SHIFT : (m_lv ? K_LETTER : K_WORD);
      chk("single_event", int'(m_shift) + int'(m_lv) + int'(m_wg), 1);
      if (sb.size() == 0) begin
        chk("unexpected_event", kind_obs, 0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", kind_obs, e.kind);
        if (kind_obs == K_SHIFT && e.kind == K_SHIFT)
          chk("shift_si", int'(m_si), int'(e.si));
        if (kind_obs == K_LETTER && e.kind == K_LETTER) begin
          mask = (1 << e.len) - 1;
          chk("letter_len", int'(m_len), e.len);
          chk("letter_err", int'(m_err), int'(e.err));
          chk("letter_q", int'(q_reg) & mask, e.q);
        end
      end
    end
  end

  initial begin
    // Reset state.
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0);

    // "E": one dot, letter, then a word gap 7 ticks after release only once.
    exp_shift(1'b0);
    exp_letter(1, 1'b0, 0);
    exp_word();
    press(2);
    gap(12);

    // "C": dash dot dash dot.
    exp_shift(1'b1);
    exp_shift(1'b0);
    exp_shift(1'b1);
    exp_shift(1'b0);
    exp_letter(4, 1'b0, 10);
    press(4); gap(1);
    press(1); gap(1);
    press(4); gap(1);
    press(1); gap(3);

    // Overflow: six dots, only five shifted.
    for (int i = 0; i < 5; i++) exp_shift(1'b0);
    exp_letter(5, 1'b1, 0);
    exp_word();
    for (int i = 0; i < 6; i++) begin
      press(1);
      if (i < 5) gap(1);
      else gap(7);
    end

    // Word gap cancelled by a press arriving on the 5th gap tick.
    exp_shift(1'b0);
    exp_letter(1, 1'b0, 0);
    exp_shift(1'b0);
    exp_letter(1, 1'b0, 0);
    exp_word();
    press(2);
    gap(4);
    cyc(1'b1, 1'b1);
    press(2);
    gap(12);

    // Key rises on the same cycle as the letter-closing gap tick.
    exp_shift(1'b1);
    exp_shift(1'b0);
    exp_letter(2, 1'b0, 2);
    press(4);
    gap(2);
    cyc(1'b1, 1'b1);
    press(1);
    gap(3);

    // Reset mid-press aborts the letter; next press starts fresh.
    exp_shift(1'b0);
    press(1);
    gap(1);
    press(2);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    key = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0);
    exp_shift(1'b1);
    exp_letter(1, 1'b0, 1);
    exp_word();
    press(4);
    gap(8);

    // Glitch filtering with MIN_PRESS=2 on the second instance.
    sel = 1'b1;
    cyc(1'b0, 1'b0);
    press(1);
    gap(5);
    exp_shift(1'b1);
    exp_shift(1'b0);
    exp_letter(2, 1'b0, 2);
    press(3); gap(1);
    press(1); gap(1);
    press(2); gap(3);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    chk("queue_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
